// File: rtl/req_queue_bank.sv
// Purpose : bank of per-requester FIFOs feeding a round-robin arbiter; a grant pops one word.
// Latency : push -> reqs 1 cycle; grant -> out_valid/out_data/out_src registered, 1 cycle.
// Backpres: push while full is dropped (full_o is registered); grants to empty queues are ignored.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   push_i/push_data_i  per-queue push strobe and data (queue i at [i*DW +: DW])
//   full_o / reqs_o     per-queue full and non-empty flags, decoded from registered counts
//   grants_i/any_grant_i  arbiter grant vector and its any-grant flag
//   out_valid_o/out_data_o/out_src_o  popped word, 1-cycle valid pulse, source index
//   err_o               (only with QBANK_ERR_STATUS_EN) sticky overflow [REQS-1:0]
//                       and spurious-grant [2*REQS-1:REQS] flags
//
// Optional feature: define QBANK_ERR_STATUS_EN to add err_o.

// Purpose : single-clock FIFO storage with pointer/count bookkeeping.
// Latency : write visible at head one cycle after push when empty.
// Backpres: none inside; the caller must only push when not full and pop when not empty.
module qbank_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so pointers wrap DEPTH-1 -> 0 by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written,
  // because a pop requires a non-zero count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

module req_queue_bank #(
  parameter int REQS  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REQS-1:0]         push_i,
  input  logic [REQS*DW-1:0]      push_data_i,
  output logic [REQS-1:0]         full_o,
  output logic [REQS-1:0]         reqs_o,
  input  logic [REQS-1:0]         grants_i,
  input  logic                    any_grant_i,
  output logic                    out_valid_o,
  output logic [DW-1:0]           out_data_o,
  output logic [$clog2(REQS)-1:0] out_src_o
`ifdef QBANK_ERR_STATUS_EN
  ,
  output logic [2*REQS-1:0]       err_o
`endif
);

  localparam int SW = $clog2(REQS);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   count [REQS];
  logic [DW-1:0]   head  [REQS];
  logic [REQS-1:0] push_acc;
  logic [REQS-1:0] pop_vec;
  logic [SW-1:0]   sel;
  logic            sel_hit;
  logic            pop_ok;

  // full_o is the pre-edge flag, so a push to a full queue is dropped even
  // when the same queue pops at this edge.
  assign push_acc = push_i & ~full_o;

  // Lowest set grant bit is the only candidate; a multi-hot grant never pops
  // a higher index, even if the lowest candidate turns out to be empty.
  always_comb begin
    sel     = '0;
    sel_hit = 1'b0;
    for (int i = REQS - 1; i >= 0; i--) begin
      if (grants_i[i]) begin
        sel     = SW'(i);
        sel_hit = 1'b1;
      end
    end
  end

  // reqs_o is registered state, so a same-edge push to an empty queue is not
  // visible here and the grant is ignored (no bypass).
  assign pop_ok = any_grant_i & sel_hit & reqs_o[sel];

  always_comb begin
    pop_vec = '0;
    if (pop_ok) pop_vec[sel] = 1'b1;
  end

  for (genvar g = 0; g < REQS; g++) begin : g_q
    qbank_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_acc[g]),
      .push_data (push_data_i[g*DW +: DW]),
      .pop       (pop_vec[g]),
      .head      (head[g]),
      .count     (count[g])
    );

    assign reqs_o[g] = (count[g] != '0);
    assign full_o[g] = (count[g] == CW'(DEPTH));
  end

  // Data and source hold their last values between pops; only valid pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_src_o   <= '0;
    end else begin
      out_valid_o <= pop_ok;
      if (pop_ok) begin
        out_data_o <= head[sel];
        out_src_o  <= sel;
      end
    end
  end

`ifdef QBANK_ERR_STATUS_EN
  logic [REQS-1:0] ovf_evt;
  logic [REQS-1:0] spur_evt;

  // Spurious grant is flagged per bit, independent of the lowest-index pick.
  assign ovf_evt  = push_i & full_o;
  assign spur_evt = grants_i & ~reqs_o & {REQS{any_grant_i}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o <= '0;
    end else begin
      err_o <= err_o | {spur_evt, ovf_evt};
    end
  end
`endif

endmodule

// File: tb/tb_req_queue_bank.sv
module tb_req_queue_bank;

  logic        clk;
  logic        rst;
  logic [3:0]  push_i;
  logic [31:0] push_data_i;
  logic [3:0]  full_o;
  logic [3:0]  reqs_o;
  logic [3:0]  grants_i;
  logic        any_grant_i;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic [1:0]  out_src_o;
`ifdef QBANK_ERR_STATUS_EN
  logic [7:0]  err_o;
`endif

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  // Reference model: one queue per requester plus the registered output word.
  logic [7:0] mq [4][$];
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic [1:0] m_src   = 2'd0;

  req_queue_bank #(
    .REQS  (4),
    .DW    (8),
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .full_o      (full_o),
    .reqs_o      (reqs_o),
    .grants_i    (grants_i),
    .any_grant_i (any_grant_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_src_o   (out_src_o)
`ifdef QBANK_ERR_STATUS_EN
    ,
    .err_o       (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_reqs();
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  function automatic logic [3:0] m_full();
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() == 4);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_src   = 2'd0;
  endtask

  // One clock edge of the queue bank, decided from the pre-edge queue sizes.
  task automatic model_update(input logic [3:0] p, input logic [31:0] d,
                              input logic [3:0] g, input logic a);
    int  k;
    bit  acc [4];
    bit  pop;
    k = -1;
    for (int i = 0; i < 4; i++) if (g[i] && k < 0) k = i;
    pop = a && (k >= 0) && (mq[k].size() > 0);
    for (int i = 0; i < 4; i++) acc[i] = p[i] && (mq[i].size() < 4);
    if (pop) begin
      m_data  = mq[k].pop_front();
      m_src   = 2'(k);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) if (acc[i]) mq[i].push_back(d[i*8 +: 8]);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cyc(input logic [3:0] p, input logic [31:0] d,
                     input logic [3:0] g, input logic a);
    push_i      = p;
    push_data_i = d;
    grants_i    = g;
    any_grant_i = a;
    @(posedge clk);
    model_update(p, d, g, a);
    @(negedge clk);
    push_i      = '0;
    push_data_i = '0;
    grants_i    = '0;
    any_grant_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0000, 32'h0, 4'b0000, 1'b0);
  endtask

  task automatic expect_pop(input string name, input logic [7:0] d, input logic [1:0] s);
    check({name, "_valid"}, 32'(out_valid_o), 32'h1);
    check({name, "_data"},  32'(out_data_o),  32'(d));
    check({name, "_src"},   32'(out_src_o),   32'(s));
  endtask

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_reqs",  32'(reqs_o),      32'(m_reqs()));
      check("cmp_full",  32'(full_o),      32'(m_full()));
      check("cmp_valid", 32'(out_valid_o), 32'(m_valid));
      check("cmp_data",  32'(out_data_o),  32'(m_data));
      check("cmp_src",   32'(out_src_o),   32'(m_src));
    end
  end

  initial begin
    rst         = 1'b1;
    push_i      = '0;
    push_data_i = '0;
    grants_i    = '0;
    any_grant_i = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    #2;
    check("rst_reqs",  32'(reqs_o),      32'h0);
    check("rst_full",  32'(full_o),      32'h0);
    check("rst_valid", 32'(out_valid_o), 32'h0);
    check("rst_data",  32'(out_data_o),  32'h0);
    check("rst_src",   32'(out_src_o),   32'h0);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    chk_en = 1'b1;

    // 1: idle
    idle(5);
    check("t1_reqs", 32'(reqs_o), 32'h0);
    check("t1_full", 32'(full_o), 32'h0);

    // 2: interleaved queues
    cyc(4'b0010, 32'h0000_A100, 4'b0000, 1'b0);
    check("t2_reqs_rise", 32'(reqs_o), 32'h2);
    cyc(4'b1010, 32'hC300_A200, 4'b0000, 1'b0);
    cyc(4'b0000, 32'h0, 4'b0010, 1'b1);
    expect_pop("t2_p1", 8'hA1, 2'd1);
    cyc(4'b0000, 32'h0, 4'b1000, 1'b1);
    expect_pop("t2_p2", 8'hC3, 2'd3);
    cyc(4'b0000, 32'h0, 4'b0010, 1'b1);
    expect_pop("t2_p3", 8'hA2, 2'd1);
    check("t2_reqs_end", 32'(reqs_o), 32'h0);
    idle(1);
    check("t2_valid_drop", 32'(out_valid_o), 32'h0);

    // 3: overflow on q0
    for (int i = 1; i <= 5; i++) begin
      cyc(4'b0001, 32'(i), 4'b0000, 1'b0);
      if (i == 3) check("t3_notfull", 32'(full_o), 32'h0);
      if (i == 4) check("t3_full", 32'(full_o), 32'h1);
    end
`ifdef QBANK_ERR_STATUS_EN
    check("t3_err_ovf", 32'(err_o[0]), 32'h1);
`endif
    for (int i = 1; i <= 4; i++) begin
      cyc(4'b0000, 32'h0, 4'b0001, 1'b1);
      expect_pop("t3_pop", 8'(i), 2'd0);
    end
    cyc(4'b0000, 32'h0, 4'b0001, 1'b1);
    check("t3_fifth_none", 32'(out_valid_o), 32'h0);

    // 4: full q2, push and pop at the same edge
    for (int i = 1; i <= 4; i++) cyc(4'b0100, 32'(8'h20 + i) << 16, 4'b0000, 1'b0);
    check("t4_full", 32'(full_o), 32'h4);
    cyc(4'b0100, 32'h0025_0000, 4'b0100, 1'b1);
    expect_pop("t4_pp", 8'h21, 2'd2);
    check("t4_after_full", 32'(full_o), 32'h0);
    for (int i = 2; i <= 4; i++) begin
      cyc(4'b0000, 32'h0, 4'b0100, 1'b1);
      expect_pop("t4_drain", 8'(8'h20 + i), 2'd2);
    end
    cyc(4'b0000, 32'h0, 4'b0100, 1'b1);
    check("t4_dropped", 32'(out_valid_o), 32'h0);

    // 5: spurious grant, multi-hot grant, no bypass, any_grant low
    cyc(4'b0000, 32'h0, 4'b0100, 1'b1);
    check("t5_empty_grant", 32'(out_valid_o), 32'h0);
`ifdef QBANK_ERR_STATUS_EN
    check("t5_err_spur", 32'(err_o[6]), 32'h1);
`endif
    cyc(4'b0110, 32'h0041_3100, 4'b0000, 1'b0);
    cyc(4'b0000, 32'h0, 4'b0110, 1'b1);
    expect_pop("t5_multi", 8'h31, 2'd1);
    check("t5_reqs", 32'(reqs_o), 32'h4);
    cyc(4'b1000, 32'h5100_0000, 4'b1000, 1'b1);
    check("t5_nobypass", 32'(out_valid_o), 32'h0);
    check("t5_reqs2", 32'(reqs_o), 32'hC);
    cyc(4'b0000, 32'h0, 4'b1000, 1'b1);
    expect_pop("t5_late", 8'h51, 2'd3);
    cyc(4'b0000, 32'h0, 4'b0100, 1'b0);
    check("t5_noany", 32'(out_valid_o), 32'h0);
    check("t5_hold", 32'(out_data_o), 32'h51);
    cyc(4'b0000, 32'h0, 4'b0100, 1'b1);
    expect_pop("t5_q2", 8'h41, 2'd2);

    // 6: asynchronous reset mid-traffic
    cyc(4'b1111, 32'h8483_8281, 4'b0000, 1'b0);
    cyc(4'b1111, 32'h9493_9291, 4'b0000, 1'b0);
    cyc(4'b0000, 32'h0, 4'b0001, 1'b1);
    expect_pop("t6_pre", 8'h81, 2'd0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("t6_rst_reqs",  32'(reqs_o),      32'h0);
    check("t6_rst_full",  32'(full_o),      32'h0);
    check("t6_rst_valid", 32'(out_valid_o), 32'h0);
    check("t6_rst_data",  32'(out_data_o),  32'h0);
    check("t6_rst_src",   32'(out_src_o),   32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2);
    check("t6_post_reqs", 32'(reqs_o), 32'h0);
    cyc(4'b0000, 32'h0, 4'b1111, 1'b1);
    check("t6_no_old", 32'(out_valid_o), 32'h0);
    cyc(4'b0100, 32'h0077_0000, 4'b0000, 1'b0);
    cyc(4'b0000, 32'h0, 4'b0100, 1'b1);
    expect_pop("t6_fresh", 8'h77, 2'd2);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
